align_shift_ctrl: RTL and testbench
===================================

Name: align_shift_ctrl

Overview:
- Multi-cycle exponent-alignment sequencer for the floating-point add/sub datapath.
- Accepts one operand pair (exp_A/B, mantis_A/B), picks the operand with the smaller exponent, and right-shifts its mantissa by the exponent difference, STEP bits per cycle, accumulating a sticky bit.
- Presents aligned mantissas and the common exponent to the downstream adder through a valid/ready handshake.
- Replaces a single-cycle barrel shift so the alignment path closes timing at full clock rate.

Parameters:
- EXP_W, 8, exponent width.
- MANT_W, 26, mantissa width: hidden bit + 23 fraction + guard + round.
- STEP, 4, maximum right-shift per cycle; legal values 1..MANT_W.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- exp_A  input  EXP_W  exponent of A.
- exp_B  input  EXP_W  exponent of B.
- mantis_A  input  MANT_W  mantissa of A.
- mantis_B  input  MANT_W  mantissa of B.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts result.
- exp_out  output  EXP_W  larger exponent (common exponent).
- mantis_out  output  MANT_W  unshifted mantissa of the larger-exponent operand.
- mantis_aligned  output  MANT_W  shifted mantissa of the smaller-exponent operand.
- sticky  output  1  OR of all bits shifted out of mantis_aligned.
- swap  output  1  1 when B was the unshifted operand (exp_B > exp_A).
- busy  output  1  1 in SHIFT state.

Behaviour:
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==SHIFT).
- Reset (rst_n=0 at a clk edge):
  - state <= IDLE; exp_out, mantis_out, mantis_aligned, sticky, swap, and the remaining-shift counter cleared to 0.
  - Reset mid-SHIFT or mid-DONE discards the operation; no output is produced for it.
- Operand selection: cmp = (exp_A >= exp_B).
  - cmp=1: A is unshifted, B is shifted, swap=0.
  - cmp=0: B is unshifted, A is shifted, swap=1.
  - Equal exponents select A as unshifted.
- diff = larger exponent - smaller exponent, unsigned, EXP_W bits, never negative.
- IDLE, accept (in_valid & in_ready at edge T):
  - Capture exp_out, mantis_out, swap, and the shifted-operand mantissa into mantis_aligned; sticky <= 0.
  - If diff==0: next state DONE; out_valid at T+1.
  - If diff >= MANT_W: mantis_aligned <= 0, sticky <= |shifted mantissa, next state DONE; out_valid at T+1.
  - Else: rem <= diff, next state SHIFT.
- SHIFT, each cycle:
  - s = min(rem, STEP); mantis_aligned <= mantis_aligned >> s; sticky <= sticky | (OR of the s LSBs shifted out); rem <= rem - s.
  - When rem - s == 0, next state DONE.
  - For 0 < diff < MANT_W, out_valid rises at T+1+ceil(diff/STEP).
  - in_valid is ignored in SHIFT.
- DONE:
  - Outputs held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: next state IDLE, so in_ready=1 the following cycle. No same-cycle turnaround; throughput is at most one op per 2+ceil(diff/STEP) cycles.
- Output registers are not cleared on leaving DONE; they are don't-care while out_valid=0.
- Inputs are sampled only on the accept edge; input changes during SHIFT/DONE have no effect.

Test Plan:
- Reset: rst_n=0 for 2 cycles during a SHIFT (diff=20) -> next cycle state IDLE, in_ready=1, out_valid=0, mantis_aligned=0, sticky=0, swap=0, busy=0.
- Equal exponents: exp_A=exp_B=0x80, mantis_A=0x2000000, mantis_B=0x3000001 -> out_valid at T+1, swap=0, exp_out=0x80, mantis_out=0x2000000, mantis_aligned=0x3000001, sticky=0.
- Multi-step shift, STEP=4: exp_A=0x85, exp_B=0x7E (diff=7), mantis_B=0x2000041 -> out_valid at T+3, swap=0, exp_out=0x85, mantis_aligned=0x0040000, sticky=1 (bit 0 and bit 6 shifted out).
- Swap with exact shift: exp_A=0x10, exp_B=0x18 (diff=8), mantis_A=0x3000000, mantis_B=0x1234567 -> out_valid at T+3, swap=1, exp_out=0x18, mantis_out=0x1234567, mantis_aligned=0x0030000, sticky=0.
- Saturation: exp_A=0x90, exp_B=0x70 (diff=32 >= 26), mantis_B=0x0000001 -> out_valid at T+1, mantis_aligned=0, sticky=1; with mantis_B=0 -> sticky=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and a new in_valid pulse is ignored; out_ready=1 -> IDLE next cycle, then the next operand is accepted.

Source files
------------

// File: rtl/align_shift_ctrl.sv
// Exponent-alignment sequencer: right-shifts the smaller-exponent
// mantissa STEP bits per cycle, collecting a sticky bit.
module align_shift_ctrl #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 26,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_A,
    input  logic [EXP_W-1:0]  exp_B,
    input  logic [MANT_W-1:0] mantis_A,
    input  logic [MANT_W-1:0] mantis_B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mantis_out,
    output logic [MANT_W-1:0] mantis_aligned,
    output logic              sticky,
    output logic              swap,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nx;
    logic [EXP_W-1:0]    exp_nx, rem, rem_nx;
    logic [MANT_W-1:0]   mout_nx, mal_nx;
    logic                sticky_nx, swap_nx;

    logic                cmp;
    logic [EXP_W-1:0]    diff;
    logic [MANT_W-1:0]   m_small;
    logic [31:0]         rem32, s32;
    logic [MANT_W-1:0]   lost;

    assign cmp     = exp_A >= exp_B;
    assign diff    = cmp ? exp_A - exp_B : exp_B - exp_A;
    assign m_small = cmp ? mantis_B : mantis_A;

    // Per-cycle shift amount and the bits it pushes off the bottom
    assign rem32 = 32'(rem);
    assign s32   = (rem32 > 32'(STEP)) ? 32'(STEP) : rem32;
    assign lost  = mantis_aligned & ~({MANT_W{1'b1}} << s32);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);

    always_comb begin
        state_nx  = state;
        exp_nx    = exp_out;
        mout_nx   = mantis_out;
        mal_nx    = mantis_aligned;
        sticky_nx = sticky;
        swap_nx   = swap;
        rem_nx    = rem;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    exp_nx    = cmp ? exp_A : exp_B;
                    mout_nx   = cmp ? mantis_A : mantis_B;
                    swap_nx   = ~cmp;
                    mal_nx    = m_small;
                    sticky_nx = 1'b0;
                    if (diff == '0) begin
                        state_nx = DONE;
                    end else if (32'(diff) >= 32'(MANT_W)) begin
                        mal_nx    = '0;
                        sticky_nx = |m_small;
                        state_nx  = DONE;
                    end else begin
                        rem_nx   = diff;
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mal_nx    = mantis_aligned >> s32;
                sticky_nx = sticky | (|lost);
                rem_nx    = rem - EXP_W'(s32);
                if (rem_nx == '0) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            exp_out        <= '0;
            mantis_out     <= '0;
            mantis_aligned <= '0;
            sticky         <= 1'b0;
            swap           <= 1'b0;
            rem            <= '0;
        end else begin
            state          <= state_nx;
            exp_out        <= exp_nx;
            mantis_out     <= mout_nx;
            mantis_aligned <= mal_nx;
            sticky         <= sticky_nx;
            swap           <= swap_nx;
            rem            <= rem_nx;
        end
    end

endmodule

// File: tb/tb_align_shift_ctrl.sv
// Bench for align_shift_ctrl: directed vector table, hand-written
// reset/backpressure sequences, and randomized ops against a model.
module tb_align_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_A, exp_B;
    logic [25:0] mantis_A, mantis_B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [25:0] mantis_out, mantis_aligned;
    logic        sticky, swap, busy;

    int checks   = 0;
    int failures = 0;

    align_shift_ctrl #(.EXP_W(8), .MANT_W(26), .STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_A(exp_A), .exp_B(exp_B),
        .mantis_A(mantis_A), .mantis_B(mantis_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .mantis_out(mantis_out),
        .mantis_aligned(mantis_aligned),
        .sticky(sticky), .swap(swap), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ea, eb;
        logic [25:0] ma, mb;
        logic [7:0]  eo;
        logic [25:0] mo, al;
        logic        st, sw;
        int          lat;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: shift the whole way at once, latency from ceil division
    function automatic vec_t model(input logic [7:0] ea, input logic [7:0] eb,
                                   input logic [25:0] ma, input logic [25:0] mb);
        vec_t v;
        int d;
        longint m;
        v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
        v.sw = (eb > ea);
        v.eo = v.sw ? eb : ea;
        v.mo = v.sw ? mb : ma;
        m    = v.sw ? longint'(ma) : longint'(mb);
        d    = v.sw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
        if (d >= 26) begin
            v.al = '0;
            v.st = (m != 0);
            v.lat = 1;
        end else begin
            v.al = 26'(m >> d);
            v.st = ((m & ((longint'(1) << d) - 1)) != 0);
            v.lat = (d == 0) ? 1 : 1 + (d + 3) / 4;
        end
        return v;
    endfunction

    task automatic garbage();
        in_valid = 1'b1;
        exp_A    = 8'($urandom);
        exp_B    = 8'($urandom);
        mantis_A = 26'($urandom);
        mantis_B = 26'($urandom);
    endtask

    task automatic check_out(input vec_t v, input string tag);
        chk({tag, ".exp_out"}, exp_out, v.eo);
        chk({tag, ".mantis_out"}, mantis_out, v.mo);
        chk({tag, ".aligned"}, mantis_aligned, v.al);
        chk({tag, ".sticky"}, sticky, v.st);
        chk({tag, ".swap"}, swap, v.sw);
    endtask

    task automatic run_op(input vec_t v, input int hold, input string tag);
        int cyc;
        int w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        if (!in_ready) begin
            chk({tag, ".in_ready_timeout"}, 0, 1);
            return;
        end
        in_valid = 1'b1;
        exp_A = v.ea; exp_B = v.eb;
        mantis_A = v.ma; mantis_B = v.mb;
        out_ready = 1'b0;
        step();
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            garbage();
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, cyc, v.lat);
        if (!out_valid) return;
        check_out(v, tag);
        for (int i = 0; i < hold; i++) begin
            garbage();
            step();
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_in_ready"}, in_ready, 0);
            check_out(v, {tag, ".hold"});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".post_in_ready"}, in_ready, 1);
        chk({tag, ".post_out_valid"}, out_valid, 0);
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{8'h80, 8'h80, 26'h2000000, 26'h3000001,
                  8'h80, 26'h2000000, 26'h3000001, 1'b0, 1'b0, 1};
        vt[1] = '{8'h85, 8'h7E, 26'h1555555, 26'h2000041,
                  8'h85, 26'h1555555, 26'h0040000, 1'b1, 1'b0, 3};
        vt[2] = '{8'h10, 8'h18, 26'h3000000, 26'h1234567,
                  8'h18, 26'h1234567, 26'h0030000, 1'b0, 1'b1, 3};
        vt[3] = '{8'h90, 8'h70, 26'h2AAAAAA, 26'h0000001,
                  8'h90, 26'h2AAAAAA, 26'h0000000, 1'b1, 1'b0, 1};
        vt[4] = '{8'h90, 8'h70, 26'h2AAAAAA, 26'h0000000,
                  8'h90, 26'h2AAAAAA, 26'h0000000, 1'b0, 1'b0, 1};
        vt[5] = '{8'h19, 8'h00, 26'h0000123, 26'h3FFFFFF,
                  8'h19, 26'h0000123, 26'h0000001, 1'b1, 1'b0, 8};
        vt[6] = '{8'h1A, 8'h00, 26'h0000123, 26'h2000000,
                  8'h1A, 26'h0000123, 26'h0000000, 1'b1, 1'b0, 1};
        vt[7] = '{8'h00, 8'h04, 26'h000000F, 26'h0ABCDEF,
                  8'h04, 26'h0ABCDEF, 26'h0000000, 1'b1, 1'b1, 2};
        vt[8] = '{8'hFF, 8'h00, 26'h3FFFFFF, 26'h0000000,
                  8'hFF, 26'h3FFFFFF, 26'h0000000, 1'b0, 1'b0, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_A = '0; exp_B = '0; mantis_A = '0; mantis_B = '0;
        step(); step();
        rst_n = 1'b1;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.exp_out", exp_out, 0);
        chk("rst.mantis_out", mantis_out, 0);
        chk("rst.aligned", mantis_aligned, 0);
        chk("rst.sticky", sticky, 0);
        chk("rst.swap", swap, 0);

        for (int i = 0; i < 9; i++)
            run_op(vt[i], (i == 0) ? 5 : i % 3, $sformatf("vec%0d", i));

        // Reset during a long shift discards the operation
        in_valid = 1'b1;
        exp_A = 8'h00; exp_B = 8'h14;
        mantis_A = 26'h3FFFFFF; mantis_B = 26'h1000000;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("midrst.busy_before", busy, 1);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.aligned", mantis_aligned, 0);
        chk("midrst.sticky", sticky, 0);
        chk("midrst.swap", swap, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst.no_output", out_valid, 0);
        end

        // Backpressure in DONE, then a fresh op is accepted
        run_op(model(8'h40, 8'h40, 26'h1111111, 26'h2222222), 5, "bp0");
        run_op(model(8'h41, 8'h3F, 26'h0F0F0F0, 26'h0000003), 0, "bp1");

        for (int n = 0; n < 200; n++) begin
            logic [7:0]  ea, eb;
            logic [25:0] ma, mb;
            ea = 8'($urandom);
            eb = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                 : 8'(int'(ea) + $urandom_range(0, 60) - 30);
            ma = 26'($urandom);
            mb = 26'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ma = ma & 26'h00000FF;
                mb = mb & 26'h00000FF;
            end
            run_op(model(ea, eb, ma, mb), $urandom_range(0, 3),
                   $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
